// File: rtl/sync_fifo_param_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_if
// Purpose : groups the write/read handshake, status and error signals of
//           sync_fifo_param into one bundle.
// Signals : WrEnable/WrData      - write request and data (master -> fifo)
//           RdEnable             - read request / FWFT pop (master -> fifo)
//           ClearErr             - clear sticky error flags (master -> fifo)
//           RdData/RdValid       - read data and its qualifier (fifo -> master)
//           Full/Empty           - occupancy status (fifo -> master)
//           AlmostFull/AlmostEmpty - threshold status (fifo -> master)
//           Count                - words stored, clog2(DEPTH)+1 bits
//           Overflow/Underflow   - sticky error flags (fifo -> master)
// Modports: master (user side), slave (fifo side).
// -----------------------------------------------------------------------------
interface sync_fifo_param_if #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             WrEnable;
  logic [WIDTH-1:0] WrData;
  logic             RdEnable;
  logic             ClearErr;
  logic [WIDTH-1:0] RdData;
  logic             RdValid;
  logic             Full;
  logic             Empty;
  logic             AlmostFull;
  logic             AlmostEmpty;
  logic [CW-1:0]    Count;
  logic             Overflow;
  logic             Underflow;

  modport master (
    output WrEnable, WrData, RdEnable, ClearErr,
    input  RdData, RdValid, Full, Empty, AlmostFull, AlmostEmpty,
           Count, Overflow, Underflow
  );

  modport slave (
    input  WrEnable, WrData, RdEnable, ClearErr,
    output RdData, RdValid, Full, Empty, AlmostFull, AlmostEmpty,
           Count, Overflow, Underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
// Purpose : single-clock FIFO with registered status flags, almost-full /
//           almost-empty thresholds, sticky overflow/underflow flags and a
//           choice of standard (registered) or first-word-fall-through read.
// Ports   : clk   - clock, all state changes on the rising edge
//           Reset - synchronous, active-high; overrides every operation
//           bus   - sync_fifo_param_if.slave (handshake, data, flags, Count)
// Params  : WIDTH, DEPTH (power of 2, >= 4), AFULL_TH, AEMPTY_TH, FWFT.
// -----------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int WIDTH     = 10,
  parameter int DEPTH     = 32,
  parameter int AFULL_TH  = 28,
  parameter int AEMPTY_TH = 4,
  parameter int FWFT      = 0
) (
  input  logic                clk,
  input  logic                Reset,
  sync_fifo_param_if.slave    bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_TH);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_TH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;

  logic             wr_acc;
  logic             rd_acc;
  logic [WIDTH-1:0] head_word;

  // Head of queue; FWFT mode shows it directly, standard mode captures it.
  assign head_word = mem[rd_ptr_q];

  always_comb begin
    // Acceptance uses only the registered flags, so a full FIFO still takes
    // a read and an empty FIFO still takes a write in the same cycle.
    wr_acc = bus.WrEnable & ~full_q;
    rd_acc = bus.RdEnable & ~empty_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

    count_d  = count_q + CW'(wr_acc) - CW'(rd_acc);
    full_d   = (count_d == DEPTH_C);
    empty_d  = (count_d == '0);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);

    // Set wins over clear when both happen in the same cycle.
    ovf_d = (bus.WrEnable & full_q)  | (ovf_q & ~bus.ClearErr);
    udf_d = (bus.RdEnable & empty_q) | (udf_q & ~bus.ClearErr);

    rd_valid_d = rd_acc;
    rd_data_d  = rd_acc ? head_word : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      afull_q    <= 1'b0;
      aempty_q   <= 1'b1;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      afull_q    <= afull_d;
      aempty_q   <= aempty_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage is never cleared; stale words stay hidden because the pointers
  // and Count restart from zero after reset.
  always_ff @(posedge clk) begin
    if (wr_acc && !Reset) mem[wr_ptr_q] <= bus.WrData;
  end

  // In FWFT mode an empty FIFO presents zero so no stale word leaks out.
  assign bus.RdData      = (FWFT != 0) ? (empty_q ? '0 : head_word) : rd_data_q;
  assign bus.RdValid     = (FWFT != 0) ? ~empty_q : rd_valid_q;
  assign bus.Full        = full_q;
  assign bus.Empty       = empty_q;
  assign bus.AlmostFull  = afull_q;
  assign bus.AlmostEmpty = aempty_q;
  assign bus.Count       = count_q;
  assign bus.Overflow    = ovf_q;
  assign bus.Underflow   = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_param
// Drives a standard-mode and an FWFT-mode sync_fifo_param with identical
// stimulus. A queue-based reference model predicts occupancy, flags and read
// data; standard-mode read data is queued as expected responses and popped
// by an independent monitor whenever RdValid is seen.
// -----------------------------------------------------------------------------
module tb_sync_fifo_param;
  localparam int W  = 10;
  localparam int D  = 32;
  localparam int AF = 28;
  localparam int AE = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         we;
  logic         re;
  logic         ce;
  logic [W-1:0] wd;

  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus_std ();
  sync_fifo_param_if #(.WIDTH(W), .DEPTH(D)) bus_fw ();

  assign bus_std.WrEnable = we;
  assign bus_std.WrData   = wd;
  assign bus_std.RdEnable = re;
  assign bus_std.ClearErr = ce;
  assign bus_fw.WrEnable  = we;
  assign bus_fw.WrData    = wd;
  assign bus_fw.RdEnable  = re;
  assign bus_fw.ClearErr  = ce;

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(0)) u_std (
    .clk   (clk),
    .Reset (rst),
    .bus   (bus_std)
  );

  sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AFULL_TH(AF), .AEMPTY_TH(AE), .FWFT(1)) u_fw (
    .clk   (clk),
    .Reset (rst),
    .bus   (bus_fw)
  );

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] mq[$];      // reference FIFO contents
  logic [W-1:0] exp_q[$];   // expected standard-mode read responses
  bit           m_ovf;
  bit           m_udf;
  logic [W-1:0] last_rd;
  bit           mon_en = 1'b0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic check_state();
    int n;
    n = mq.size();
    check("count",       32'(bus_std.Count),       n);
    check("full",        32'(bus_std.Full),        32'(n == D));
    check("empty",       32'(bus_std.Empty),       32'(n == 0));
    check("almost_full", 32'(bus_std.AlmostFull),  32'(n >= AF));
    check("almost_empty",32'(bus_std.AlmostEmpty), 32'(n <= AE));
    check("overflow",    32'(bus_std.Overflow),    32'(m_ovf));
    check("underflow",   32'(bus_std.Underflow),   32'(m_udf));
    check("rddata_hold", 32'(bus_std.RdData),      32'(last_rd));
    check("fw_count",    32'(bus_fw.Count),        n);
    check("fw_empty",    32'(bus_fw.Empty),        32'(n == 0));
    check("fw_overflow", 32'(bus_fw.Overflow),     32'(m_ovf));
    check("fw_rdvalid",  32'(bus_fw.RdValid),      32'(n != 0));
    if (n != 0) check("fw_rddata", 32'(bus_fw.RdData), 32'(mq[0]));
  endtask

  // One clock of stimulus: model the edge, then compare just after it.
  task automatic step(input logic w, input logic [W-1:0] d, input logic r,
                      input logic c, input logic rs);
    bit full_m, empty_m;
    we = w; wd = d; re = r; ce = c; rst = rs;
    if (rs) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
      last_rd = '0;
    end else begin
      full_m  = (mq.size() == D);
      empty_m = (mq.size() == 0);
      if (r && !empty_m) begin
        last_rd = mq.pop_front();
        exp_q.push_back(last_rd);
      end
      if (w && !full_m) mq.push_back(d);
      m_ovf = (w && full_m)  || (m_ovf && !c);
      m_udf = (r && empty_m) || (m_udf && !c);
    end
    @(posedge clk);
    #1;
    check_state();
    if (rs) check("fw_rddata_reset", 32'(bus_fw.RdData), 0);
  endtask

  // Scoreboard monitor: every RdValid must match the oldest expected read.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mon_en && bus_std.RdValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_rdvalid: got RdValid=1 data 0x%0h, expected no read at %0t",
                 bus_std.RdData, $time);
      end else begin
        e = exp_q.pop_front();
        $display("[TB] read 0x%0h expected 0x%0h", bus_std.RdData, e);
        check("rd_data", 32'(bus_std.RdData), 32'(e));
      end
    end
  end

  initial begin
    rst = 1'b1; we = 1'b0; re = 1'b0; ce = 1'b0; wd = '0;
    m_ovf = 1'b0; m_udf = 1'b0; last_rd = '0;

    step(0, '0, 0, 0, 1);
    mon_en = 1'b1;
    step(0, '0, 0, 0, 1);

    // Fill to full, then one overflowing write.
    for (int i = 0; i < 33; i++) step(1, W'(i), 0, 0, 0);
    // Drain, then one underflowing read.
    for (int i = 0; i < 33; i++) step(0, '0, 1, 0, 0);
    step(0, '0, 0, 1, 0);

    // Simultaneous read/write at full and at empty.
    for (int i = 0; i < 32; i++) step(1, W'(i + 100), 0, 0, 0);
    step(1, 10'h3FF, 1, 0, 0);
    for (int i = 0; i < 31; i++) step(0, '0, 1, 0, 0);
    step(1, 10'h2AA, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 1, 0);

    // Pointer wrap.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 20; i++) step(1, W'(k * 20 + i), 0, 0, 0);
      for (int i = 0; i < 20; i++) step(0, '0, 1, 0, 0);
    end

    // FWFT visibility of a single word.
    step(1, 10'h155, 0, 0, 0);
    step(0, '0, 1, 0, 0);

    // Reset mid-operation at Count=17 with Overflow set.
    for (int i = 0; i < 32; i++) step(1, W'(i + 200), 0, 0, 0);
    step(1, 10'h111, 0, 0, 0);
    for (int i = 0; i < 15; i++) step(0, '0, 1, 0, 0);
    step(1, 10'h0AB, 1, 0, 1);

    // ClearErr coinciding with an overflow event, then a plain clear.
    for (int i = 0; i < 32; i++) step(1, W'(i + 300), 0, 0, 0);
    step(1, 10'h123, 0, 0, 0);
    step(1, 10'h124, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 0, 1);

    // Randomised traffic with alternating fill/drain bias.
    for (int i = 0; i < 3000; i++) begin
      int  wp;
      logic w, r, c, rs;
      wp = ((i / 400) % 2 != 0) ? 30 : 70;
      w  = ($urandom_range(0, 99) < wp);
      r  = ($urandom_range(0, 99) < (100 - wp));
      c  = ($urandom_range(0, 99) < 3);
      rs = ($urandom_range(0, 999) < 3);
      step(w, W'($urandom), r, c, rs);
    end

    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 0);
    check("scoreboard_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
